wca_reg_core: RTL and testbench
===============================

Name: wca_reg_core

Overview:
- Parametrised successor to the fixed 8-bit enable/clear register core.
- One configurable-width control/status register with:
  - byte-lane write enables
  - per-bit modes: read/write, write-1-to-clear status, self-clearing strobe
  - optional double-buffered commit, so a multi-byte value reaches hardware atomically
  - change-detect pulse
- Sits between the host register-bus decode and the DSP/RF control logic; one instance per register address.

Parameters:
- WIDTH, 8, register width in bits (1..64); byte lanes NL = (WIDTH+7)/8.
- RESET_VAL, 0, value loaded on reset (SC_MASK bits forced 0 regardless).
- W1C_MASK, 0, bits that are hardware-set and host write-1-to-clear.
- SC_MASK, 0, bits that self-clear one cycle after being written 1.
- DBUF, 0, 1 = RW bits double-buffered (staged, copied to Q on Commit); 0 = Q follows writes directly.

Ports:
- Clock, input, 1, sole clock, all state updates on rising edge.
- Aclr, input, 1, synchronous active-high reset (despite the legacy name, it is sampled on Clock only).
- Data, input, WIDTH, host write data.
- Enable, input, 1, write strobe, one write per cycle high.
- ByteEn, input, NL, lane enables; lane i = bits [8i+7:8i], last lane truncated to WIDTH.
- HwSet, input, WIDTH, hardware set requests (used only for W1C_MASK bits).
- Commit, input, 1, transfer staged RW bits to Q (ignored when DBUF=0).
- Q, output, WIDTH, register value seen by hardware/readback.
- Stage, output, WIDTH, staged value (equals Q when DBUF=0).
- Pending, output, 1, staged RW bits written since last commit (always 0 when DBUF=0).
- Changed, output, 1, one-cycle pulse when Q changes.

Behaviour:
- Reset (Aclr=1 at edge, dominates all other inputs):
  - Stage = Q = RESET_VAL & ~SC_MASK
  - Pending = 0, Changed = 0
- A bit is lane-written when Enable=1 and its ByteEn lane = 1.
- RW bits (not in W1C_MASK or SC_MASK):
  - lane-written → Stage <= Data bit.
  - DBUF=0: Q bit = Stage bit; new value visible the cycle after the write edge (latency 1).
  - DBUF=1: Q bit <= Stage-next bit on an edge with Commit=1. Stage-next includes a write in the same cycle, so write+Commit together lands the new data in Q after that edge.
- W1C bits, always live (no double buffering):
  - next = (cur & ~(lane-written & Data)) | HwSet.
  - Set wins over simultaneous clear.
  - Writing 0 has no effect.
- SC bits, always live:
  - lane-written with Data=1 → bit = 1 for exactly one cycle, then 0.
  - Back-to-back writes of 1 hold it high continuously.
  - Writing 0 forces 0.
  - HwSet is ignored.
- Bits in both W1C_MASK and SC_MASK are treated as W1C; this overlap is illegal config and is flagged by a simulation-time assertion.
- Pending (DBUF=1):
  - set at the edge after any write touching an RW bit.
  - cleared by Commit.
  - Write+Commit in the same cycle → Pending = 0.
  - Commit with Pending=0 is legal and copies Stage (no change).
- Changed:
  - registered; high for exactly the one cycle in which Q first shows a value different from the previous cycle.
  - an SC pulse produces Changed on both its rise and its fall.
- ByteEn = 0 with Enable = 1: no write, no Pending.
- Reset mid-operation:
  - discards staged data and any pending commit.
  - Changed does not pulse on the reset edge or on the cycle after reset release.

Test Plan:
- WIDTH=16, DBUF=0, reset → Q=RESET_VAL. Write Data=16'hA55A, ByteEn=2'b01 → Q=16'h005A next cycle, Changed pulses 1 cycle. Repeat the same write → Changed stays 0.
- WIDTH=16, DBUF=1:
  - write 16'h1234, ByteEn=11 → Stage=1234, Q unchanged, Pending=1.
  - Commit → Q=1234, Pending=0, Changed pulse.
  - write 16'hBEEF with Commit in the same cycle → Q=BEEF, Pending=0.
- W1C_MASK=8'h0F:
  - HwSet=8'h05 → Q[3:0]=5.
  - write Data=8'h01 → Q[3:0]=4.
  - same-cycle HwSet=8'h04 + write Data=8'h04 → bit2 stays 1.
  - HwSet on bit 7 → ignored.
- SC_MASK=8'h80:
  - write 8'h80 → Q[7]=1 for exactly one cycle, Changed pulses twice.
  - three consecutive writes → Q[7] high 3 cycles.
- WIDTH=12 (NL=2, lane1 = bits 11:8):
  - write 12'hFFF, ByteEn=2'b10 → Q=12'hF00.
  - Aclr asserted together with Enable → Q=RESET_VAL, Pending=0, Changed=0 the following cycle.

Source files
------------

// File: rtl/wca_reg_core.sv
// Configurable-width control/status register: byte-lane writes, per-bit RW / W1C / self-clearing
// modes, optional double-buffered commit of RW bits, and a registered change-detect pulse.
module wca_reg_core #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] W1C_MASK  = '0,
  parameter logic [WIDTH-1:0] SC_MASK   = '0,
  parameter bit               DBUF      = 1'b0
) (
  input  logic                       Clock,
  input  logic                       Aclr,
  input  logic [WIDTH-1:0]           Data,
  input  logic                       Enable,
  input  logic [(WIDTH+7)/8-1:0]     ByteEn,
  input  logic [WIDTH-1:0]           HwSet,
  input  logic                       Commit,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           Stage,
  output logic                       Pending,
  output logic                       Changed
);

  // Overlapping W1C/SC bits behave as W1C, so SC only owns what W1C does not claim.
  localparam logic [WIDTH-1:0] W1C_BITS = W1C_MASK;
  localparam logic [WIDTH-1:0] SC_BITS  = SC_MASK & ~W1C_MASK;
  localparam logic [WIDTH-1:0] RW_BITS  = ~(W1C_BITS | SC_BITS);
  localparam logic [WIDTH-1:0] RST_VAL  = RESET_VAL & ~SC_MASK;

  logic [WIDTH-1:0] wr_mask;
  logic [WIDTH-1:0] stage_d, stage_q;
  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] rw_next, w1c_next, sc_next;
  logic             pending_d, pending_q;
  logic             changed_d, changed_q;

  always_comb begin
    wr_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      wr_mask[i] = Enable & ByteEn[i/8];
    end

    stage_d  = (stage_q & ~wr_mask) | (Data & wr_mask);
    rw_next  = DBUF ? (Commit ? stage_d : q_q) : stage_d;
    // Hardware set is ORed in last so it wins over a same-cycle host clear.
    w1c_next = (q_q & ~(wr_mask & Data)) | HwSet;
    sc_next  = wr_mask & Data;

    q_d       = (rw_next & RW_BITS) | (w1c_next & W1C_BITS) | (sc_next & SC_BITS);
    pending_d = DBUF && !Commit && (pending_q || (|(wr_mask & RW_BITS)));
    changed_d = (q_d != q_q);
  end

  always_ff @(posedge Clock) begin
    if (Aclr) begin
      stage_q   <= RST_VAL;
      q_q       <= RST_VAL;
      pending_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      stage_q   <= stage_d;
      q_q       <= q_d;
      pending_q <= pending_d;
      changed_q <= changed_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Aclr) begin
      assert ((W1C_MASK & SC_MASK) == '0)
        else $error("wca_reg_core: W1C_MASK and SC_MASK overlap");
    end
  end

  assign Q       = q_q;
  assign Stage   = DBUF ? ((stage_q & RW_BITS) | (q_q & ~RW_BITS)) : q_q;
  assign Pending = pending_q;
  assign Changed = changed_q;

endmodule

// File: tb/tb_wca_reg_core.sv
// Directed self-checking bench for wca_reg_core: five instances cover plain RW, double buffering,
// W1C, self-clearing strobe and a truncated 12-bit lane layout.
module tb_wca_reg_core;

  logic        clock = 1'b0;
  logic        aclr;
  logic [15:0] data;
  logic [4:0]  enable;
  logic [1:0]  byteEn;
  logic [15:0] hwSet;
  logic        commit;

  logic [15:0] qRw, stageRw, qDb, stageDb;
  logic [7:0]  qW1c, stageW1c, qSc, stageSc;
  logic [11:0] qW12, stageW12;
  logic        pendRw, pendDb, pendW1c, pendSc, pendW12;
  logic        chgRw, chgDb, chgW1c, chgSc, chgW12;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  wca_reg_core #(.WIDTH(16), .RESET_VAL(16'h0000), .DBUF(1'b0)) uRw (
    .Clock(clock), .Aclr(aclr), .Data(data), .Enable(enable[0]), .ByteEn(byteEn),
    .HwSet(hwSet), .Commit(commit), .Q(qRw), .Stage(stageRw), .Pending(pendRw), .Changed(chgRw));

  wca_reg_core #(.WIDTH(16), .RESET_VAL(16'h00FF), .DBUF(1'b1)) uDb (
    .Clock(clock), .Aclr(aclr), .Data(data), .Enable(enable[1]), .ByteEn(byteEn),
    .HwSet(hwSet), .Commit(commit), .Q(qDb), .Stage(stageDb), .Pending(pendDb), .Changed(chgDb));

  wca_reg_core #(.WIDTH(8), .W1C_MASK(8'h0F)) uW1c (
    .Clock(clock), .Aclr(aclr), .Data(data[7:0]), .Enable(enable[2]), .ByteEn(byteEn[0:0]),
    .HwSet(hwSet[7:0]), .Commit(commit), .Q(qW1c), .Stage(stageW1c), .Pending(pendW1c),
    .Changed(chgW1c));

  // RESET_VAL sets the strobe bit on purpose: reset must still force it low.
  wca_reg_core #(.WIDTH(8), .RESET_VAL(8'h80), .SC_MASK(8'h80)) uSc (
    .Clock(clock), .Aclr(aclr), .Data(data[7:0]), .Enable(enable[3]), .ByteEn(byteEn[0:0]),
    .HwSet(hwSet[7:0]), .Commit(commit), .Q(qSc), .Stage(stageSc), .Pending(pendSc),
    .Changed(chgSc));

  wca_reg_core #(.WIDTH(12), .RESET_VAL(12'h000)) uW12 (
    .Clock(clock), .Aclr(aclr), .Data(data[11:0]), .Enable(enable[4]), .ByteEn(byteEn),
    .HwSet(hwSet[11:0]), .Commit(commit), .Q(qW12), .Stage(stageW12), .Pending(pendW12),
    .Changed(chgW12));

  // Drive one cycle of inputs, take the rising edge, then settle before sampling.
  task automatic applyStimulus(input logic rst, input logic [4:0] en, input logic [15:0] d,
                               input logic [1:0] be, input logic [15:0] hw, input logic cm);
    aclr   = rst;
    enable = en;
    data   = d;
    byteEn = be;
    hwSet  = hw;
    commit = cm;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
      end
  endtask

  initial begin
    applyStimulus(1'b1, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b0);
    applyStimulus(1'b1, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b0);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b0);
    checkOutput("rst_q_rw", qRw, 16'h0000);
    checkOutput("rst_q_db", qDb, 16'h00FF);
    checkOutput("rst_stage_db", stageDb, 16'h00FF);
    checkOutput("rst_pend_db", {15'd0, pendDb}, 16'h0000);
    checkOutput("rst_q_sc", {8'd0, qSc}, 16'h0000);
    checkOutput("rst_q_w1c", {8'd0, qW1c}, 16'h0000);
    checkOutput("rst_chg_any", {11'd0, chgRw, chgDb, chgW1c, chgSc, chgW12}, 16'h0000);

    // Plain RW, DBUF=0: only lane 0 takes the write.
    applyStimulus(1'b0, 5'b00001, 16'hA55A, 2'b01, 16'h0000, 1'b0);
    checkOutput("rw_q_lane0", qRw, 16'h005A);
    checkOutput("rw_chg_rise", {15'd0, chgRw}, 16'h0001);
    checkOutput("rw_stage_eq_q", stageRw, 16'h005A);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b01, 16'h0000, 1'b0);
    checkOutput("rw_chg_one_cycle", {15'd0, chgRw}, 16'h0000);
    applyStimulus(1'b0, 5'b00001, 16'hA55A, 2'b01, 16'h0000, 1'b0);
    checkOutput("rw_same_write_q", qRw, 16'h005A);
    checkOutput("rw_same_write_chg", {15'd0, chgRw}, 16'h0000);
    checkOutput("rw_pend_zero", {15'd0, pendRw}, 16'h0000);

    // Double buffered: stage, commit, then write+commit together.
    applyStimulus(1'b0, 5'b00010, 16'h1234, 2'b11, 16'h0000, 1'b0);
    checkOutput("db_stage", stageDb, 16'h1234);
    checkOutput("db_q_held", qDb, 16'h00FF);
    checkOutput("db_pend_set", {15'd0, pendDb}, 16'h0001);
    checkOutput("db_chg_none", {15'd0, chgDb}, 16'h0000);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b1);
    checkOutput("db_commit_q", qDb, 16'h1234);
    checkOutput("db_commit_pend", {15'd0, pendDb}, 16'h0000);
    checkOutput("db_commit_chg", {15'd0, chgDb}, 16'h0001);
    applyStimulus(1'b0, 5'b00010, 16'hBEEF, 2'b11, 16'h0000, 1'b1);
    checkOutput("db_wc_q", qDb, 16'hBEEF);
    checkOutput("db_wc_pend", {15'd0, pendDb}, 16'h0000);
    checkOutput("db_wc_chg", {15'd0, chgDb}, 16'h0001);
    applyStimulus(1'b0, 5'b00010, 16'h0000, 2'b00, 16'h0000, 1'b0);
    checkOutput("db_be0_pend", {15'd0, pendDb}, 16'h0000);
    checkOutput("db_be0_stage", stageDb, 16'hBEEF);
    applyStimulus(1'b0, 5'b00010, 16'h0000, 2'b10, 16'h0000, 1'b0);
    checkOutput("db_lane1_stage", stageDb, 16'h00EF);
    checkOutput("db_lane1_q", qDb, 16'hBEEF);
    checkOutput("db_lane1_pend", {15'd0, pendDb}, 16'h0001);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b1);
    checkOutput("db_commit2_q", qDb, 16'h00EF);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b1);
    checkOutput("db_idle_commit_q", qDb, 16'h00EF);
    checkOutput("db_idle_commit_chg", {15'd0, chgDb}, 16'h0000);

    // W1C bits [3:0]; bit 7 is RW so HwSet there is ignored.
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b01, 16'h0005, 1'b0);
    checkOutput("w1c_hwset", {8'd0, qW1c}, 16'h0005);
    checkOutput("w1c_hwset_chg", {15'd0, chgW1c}, 16'h0001);
    applyStimulus(1'b0, 5'b00100, 16'h0001, 2'b01, 16'h0000, 1'b0);
    checkOutput("w1c_clear_b0", {8'd0, qW1c}, 16'h0004);
    applyStimulus(1'b0, 5'b00100, 16'h0004, 2'b01, 16'h0004, 1'b0);
    checkOutput("w1c_set_wins", {8'd0, qW1c}, 16'h0004);
    checkOutput("w1c_set_wins_chg", {15'd0, chgW1c}, 16'h0000);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b01, 16'h0080, 1'b0);
    checkOutput("w1c_hw_b7_ignored", {8'd0, qW1c}, 16'h0004);
    applyStimulus(1'b0, 5'b00100, 16'h0000, 2'b01, 16'h0000, 1'b0);
    checkOutput("w1c_write0_noop", {8'd0, qW1c}, 16'h0004);
    applyStimulus(1'b0, 5'b00100, 16'h000F, 2'b01, 16'h0000, 1'b0);
    checkOutput("w1c_clear_all", {8'd0, qW1c}, 16'h0000);

    // Self-clearing strobe on bit 7.
    applyStimulus(1'b0, 5'b01000, 16'h0080, 2'b01, 16'h0000, 1'b0);
    checkOutput("sc_rise_q", {8'd0, qSc}, 16'h0080);
    checkOutput("sc_rise_chg", {15'd0, chgSc}, 16'h0001);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b01, 16'h0000, 1'b0);
    checkOutput("sc_fall_q", {8'd0, qSc}, 16'h0000);
    checkOutput("sc_fall_chg", {15'd0, chgSc}, 16'h0001);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b01, 16'h0080, 1'b0);
    checkOutput("sc_hwset_ignored", {8'd0, qSc}, 16'h0000);
    checkOutput("sc_quiet_chg", {15'd0, chgSc}, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'b01000, 16'h0080, 2'b01, 16'h0000, 1'b0);
      checkOutput($sformatf("sc_hold_q%0d", i), {8'd0, qSc}, 16'h0080);
      checkOutput($sformatf("sc_hold_chg%0d", i), {15'd0, chgSc}, (i == 0) ? 16'h0001 : 16'h0000);
    end
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b01, 16'h0000, 1'b0);
    checkOutput("sc_hold_end_q", {8'd0, qSc}, 16'h0000);

    // 12-bit register: lane 1 is the truncated nibble [11:8].
    applyStimulus(1'b0, 5'b10000, 16'h0FFF, 2'b10, 16'h0000, 1'b0);
    checkOutput("w12_lane1", {4'd0, qW12}, 16'h0F00);
    checkOutput("w12_lane1_chg", {15'd0, chgW12}, 16'h0001);

    // Leave a staged write pending on uDb, then reset together with writes everywhere.
    applyStimulus(1'b0, 5'b00010, 16'h5555, 2'b11, 16'h0000, 1'b0);
    checkOutput("db_prereset_pend", {15'd0, pendDb}, 16'h0001);
    applyStimulus(1'b1, 5'b11111, 16'h0FFF, 2'b11, 16'h0000, 1'b1);
    checkOutput("rst_mid_w12_q", {4'd0, qW12}, 16'h0000);
    checkOutput("rst_mid_db_q", qDb, 16'h00FF);
    checkOutput("rst_mid_db_stage", stageDb, 16'h00FF);
    checkOutput("rst_mid_db_pend", {15'd0, pendDb}, 16'h0000);
    checkOutput("rst_mid_rw_q", qRw, 16'h0000);
    checkOutput("rst_mid_chg", {11'd0, chgRw, chgDb, chgW1c, chgSc, chgW12}, 16'h0000);
    applyStimulus(1'b0, 5'b00000, 16'h0000, 2'b11, 16'h0000, 1'b0);
    checkOutput("rst_rel_chg", {11'd0, chgRw, chgDb, chgW1c, chgSc, chgW12}, 16'h0000);
    checkOutput("rst_rel_w12_q", {4'd0, qW12}, 16'h0000);
    checkOutput("rst_rel_db_pend", {15'd0, pendDb}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
